// File: rtl/sm3_msg_arb.sv
`default_nettype none
// sm3_msg_arb: round-robin arbiter sharing one SM3 padder and compression engine
// among NUM_REQ message requesters; a grant is held from first beat until hash completion.
module sm3_msg_arb #(
  parameter int NUM_REQ = 2,
  parameter int DW      = 64,
  parameter int BW      = DW/8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ*DW-1:0] req_d_i,
  input  logic [NUM_REQ*BW-1:0] req_vld_byte_i,
  input  logic [NUM_REQ-1:0]    req_vld_i,
  input  logic [NUM_REQ-1:0]    req_lst_i,
  output logic [NUM_REQ-1:0]    req_rdy_o,
  output logic [DW-1:0]         msg_inpt_d_o,
  output logic [BW-1:0]         msg_inpt_vld_byte_o,
  output logic                  msg_inpt_vld_o,
  output logic                  msg_inpt_lst_o,
  input  logic                  msg_inpt_rdy_i,
  input  logic                  hash_done_i,
  output logic [NUM_REQ-1:0]    rslt_vld_o,
  output logic [2:0]            gnt_id_o,
  output logic                  busy_o,
  output logic                  err_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT     = 2'd1,
    WAIT_RSLT = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t              state;
  logic [2:0]          rr_ptr;
  logic [15:0]         beat_cnt;

  logic [7:0]          vld_pad;
  logic [3:0]          idx;
  logic                sel_found;
  logic [2:0]          sel_id;

  logic [DW-1:0]       gnt_d;
  logic [BW-1:0]       gnt_vb;
  logic                gnt_vld;
  logic                gnt_lst;
  logic [NUM_REQ-1:0]  gnt_onehot;

  logic                in_grant;
  logic                xfer;

  // Rotating priority search: first asserting requester at or above rr_ptr, with wrap.
  always_comb begin
    vld_pad                = '0;
    vld_pad[NUM_REQ-1:0]   = req_vld_i;
    sel_found              = 1'b0;
    sel_id                 = '0;
    idx                    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, rr_ptr} + 4'(i);
      if (idx >= 4'(NUM_REQ)) begin
        idx = idx - 4'(NUM_REQ);
      end
      if (!sel_found && vld_pad[idx[2:0]]) begin
        sel_found = 1'b1;
        sel_id    = idx[2:0];
      end
    end
  end

  always_comb begin
    gnt_d      = '0;
    gnt_vb     = '0;
    gnt_vld    = 1'b0;
    gnt_lst    = 1'b0;
    gnt_onehot = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_id_o == 3'(k)) begin
        gnt_d         = req_d_i[k*DW +: DW];
        gnt_vb        = req_vld_byte_i[k*BW +: BW];
        gnt_vld       = req_vld_i[k];
        gnt_lst       = req_lst_i[k];
        gnt_onehot[k] = 1'b1;
      end
    end
  end

  // The padder samples valid without looking at its own ready, so valid is qualified here.
  assign in_grant            = (state == GRANT);
  assign xfer                = in_grant && gnt_vld && msg_inpt_rdy_i;
  assign req_rdy_o           = {NUM_REQ{in_grant && msg_inpt_rdy_i}} & gnt_onehot;
  assign msg_inpt_vld_o      = xfer;
  assign msg_inpt_lst_o      = xfer && gnt_lst;
  assign msg_inpt_d_o        = gnt_d;
  assign msg_inpt_vld_byte_o = gnt_vb;
  assign busy_o              = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      gnt_id_o   <= '0;
      rslt_vld_o <= '0;
      err_o      <= 1'b0;
      beat_cnt   <= '0;
    end else begin
      if (hash_done_i && (state != WAIT_RSLT)) begin
        err_o <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (sel_found) begin
            gnt_id_o <= sel_id;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (xfer) begin
            if (beat_cnt != 16'hFFFF) begin
              beat_cnt <= beat_cnt + 16'd1;
            end
            if (gnt_lst) begin
              state <= WAIT_RSLT;
            end
          end
        end
        WAIT_RSLT: begin
          if (hash_done_i) begin
            rslt_vld_o <= gnt_onehot;
            state      <= DONE;
          end
        end
        DONE: begin
          // Moving the pointer past the finished owner keeps it from winning twice in a row.
          rslt_vld_o <= '0;
          rr_ptr     <= (gnt_id_o == 3'(NUM_REQ-1)) ? 3'd0 : gnt_id_o + 3'd1;
          beat_cnt   <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sm3_msg_arb.sv
`default_nettype none
// tb_sm3_msg_arb: scoreboard bench for sm3_msg_arb with a 2-requester, 64-bit configuration.
module tb_sm3_msg_arb;

  localparam int NUM_REQ = 2;
  localparam int DW      = 64;
  localparam int BW      = 8;
  localparam int TMO     = 500;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NUM_REQ*DW-1:0] req_d = '0;
  logic [NUM_REQ*BW-1:0] req_vb = '0;
  logic [NUM_REQ-1:0]    req_vld = '0;
  logic [NUM_REQ-1:0]    req_lst = '0;
  logic [NUM_REQ-1:0]    req_rdy;
  logic [DW-1:0]         msg_d;
  logic [BW-1:0]         msg_vb;
  logic                  msg_vld;
  logic                  msg_lst;
  logic                  msg_rdy = 1'b1;
  logic                  eng_pulse = 1'b0;
  logic                  stray_pulse = 1'b0;
  logic                  hash_done;
  logic [NUM_REQ-1:0]    rslt_vld;
  logic [2:0]            gnt_id;
  logic                  busy;
  logic                  err;

  assign hash_done = eng_pulse | stray_pulse;

  sm3_msg_arb #(.NUM_REQ(NUM_REQ), .DW(DW), .BW(BW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .req_d_i             (req_d),
    .req_vld_byte_i      (req_vb),
    .req_vld_i           (req_vld),
    .req_lst_i           (req_lst),
    .req_rdy_o           (req_rdy),
    .msg_inpt_d_o        (msg_d),
    .msg_inpt_vld_byte_o (msg_vb),
    .msg_inpt_vld_o      (msg_vld),
    .msg_inpt_lst_o      (msg_lst),
    .msg_inpt_rdy_i      (msg_rdy),
    .hash_done_i         (hash_done),
    .rslt_vld_o          (rslt_vld),
    .gnt_id_o            (gnt_id),
    .busy_o              (busy),
    .err_o               (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  vb;
    logic        lst;
    logic [2:0]  id;
  } beat_t;

  beat_t              exp_q[$];
  logic [NUM_REQ-1:0] exp_rslt[$];
  beat_t              mb;
  int                 n_checks = 0;
  int                 n_fails  = 0;
  int                 n_beats  = 0;
  int                 done_delay = 4;
  logic               legit_prev = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expv);
    end
  endtask

  function automatic logic [63:0] beat_data(input logic [7:0] tag, input int b);
    logic [7:0] bb;
    bb = 8'(b);
    return {tag, bb, 16'hA5C3, {4{tag ^ bb}}};
  endfunction

  task automatic push_beat(input int k, input logic [7:0] tag, input int b,
                           input logic [7:0] vb, input logic lst);
    beat_t e;
    e.d   = beat_data(tag, b);
    e.vb  = vb;
    e.lst = lst;
    e.id  = 3'(k);
    exp_q.push_back(e);
  endtask

  task automatic push_msg(input int k, input int n, input logic [7:0] last_vb, input logic [7:0] tag);
    logic [NUM_REQ-1:0] oh;
    for (int b = 0; b < n; b++) begin
      push_beat(k, tag, b, (b == n-1) ? last_vb : 8'hFF, b == n-1);
    end
    oh = '0;
    oh[k] = 1'b1;
    exp_rslt.push_back(oh);
  endtask

  // Returns at posedge+1 after the beat on lane k has been accepted.
  task automatic wait_hs(input int k);
    bit got;
    int t;
    got = 0;
    t   = 0;
    while (!got && t < TMO) begin
      @(negedge clk);
      if (req_vld[k] && req_rdy[k]) got = 1;
      t++;
      @(posedge clk);
      #1;
    end
    if (!got) check("handshake_timeout", 64'd1, 64'd0);
  endtask

  task automatic send_msg(input int k, input int n, input logic [7:0] last_vb, input logic [7:0] tag);
    for (int b = 0; b < n; b++) begin
      req_d[k*DW +: DW]  = beat_data(tag, b);
      req_vb[k*BW +: BW] = (b == n-1) ? last_vb : 8'hFF;
      req_lst[k]         = (b == n-1);
      req_vld[k]         = 1'b1;
      wait_hs(k);
    end
    req_vld[k] = 1'b0;
    req_lst[k] = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int t = 0; t < TMO && !ok; t++) begin
      @(negedge clk);
      #1;
      if (!busy && exp_q.size() == 0 && exp_rslt.size() == 0) ok = 1;
    end
    if (!ok) check("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_beats(input int target);
    bit ok;
    ok = 0;
    for (int t = 0; t < TMO && !ok; t++) begin
      @(negedge clk);
      #1;
      if (n_beats >= target) ok = 1;
    end
    if (!ok) check("beat_wait_timeout", 64'd1, 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst     = 1'b1;
    req_vld = '0;
    req_lst = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Padder-side monitor and result scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (msg_vld) begin
        n_beats++;
        if (exp_q.size() == 0) begin
          check("beat_unexpected", 64'd1, 64'd0);
        end else begin
          mb = exp_q.pop_front();
          check("beat_data", msg_d, mb.d);
          check("beat_vld_byte", 64'(msg_vb), 64'(mb.vb));
          check("beat_lst", 64'(msg_lst), 64'(mb.lst));
          check("beat_gnt_id", 64'(gnt_id), 64'(mb.id));
        end
      end
      if (legit_prev) begin
        if (exp_rslt.size() == 0) check("rslt_unexpected", 64'(rslt_vld), 64'd0);
        else check("rslt_vld", 64'(rslt_vld), 64'(exp_rslt.pop_front()));
      end else if (rslt_vld != '0) begin
        check("rslt_spurious", 64'(rslt_vld), 64'd0);
      end
      legit_prev = eng_pulse;
    end else begin
      legit_prev = 1'b0;
    end
  end

  // Compression engine model: completes done_delay cycles after the last beat.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && msg_vld && msg_lst) begin
        repeat (done_delay) @(posedge clk);
        #1 eng_pulse = 1'b1;
        @(posedge clk);
        #1 eng_pulse = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    #23 rst = 1'b0;
    @(negedge clk);
    check("rst_gnt_id", 64'(gnt_id), 64'd0);
    check("rst_req_rdy", 64'(req_rdy), 64'd0);
    check("rst_msg_vld", 64'(msg_vld), 64'd0);
    check("rst_msg_lst", 64'(msg_lst), 64'd0);
    check("rst_rslt", 64'(rslt_vld), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);

    // Three-beat message from requester 0, partial last beat.
    done_delay = 10;
    base = n_beats;
    push_msg(0, 3, 8'hF0, 8'h11);
    send_msg(0, 3, 8'hF0, 8'h11);
    wait_idle();
    check("t1_beats", 64'(n_beats - base), 64'd3);
    check("t1_gnt_id", 64'(gnt_id), 64'd0);
    check("t1_busy", 64'(busy), 64'd0);

    // Both requesters contending from reset: 0, 1, 0.
    do_reset();
    done_delay = 3;
    push_msg(0, 2, 8'hFF, 8'h21);
    push_msg(1, 3, 8'h0F, 8'h22);
    push_msg(0, 1, 8'h03, 8'h23);
    fork
      begin
        send_msg(0, 2, 8'hFF, 8'h21);
        send_msg(0, 1, 8'h03, 8'h23);
      end
      send_msg(1, 3, 8'h0F, 8'h22);
    join
    wait_idle();

    // Padder stall mid-message.
    base = n_beats;
    push_msg(1, 6, 8'h3F, 8'h31);
    fork
      send_msg(1, 6, 8'h3F, 8'h31);
      begin
        wait_beats(base + 2);
        @(posedge clk);
        #1 msg_rdy = 1'b0;
        repeat (4) begin
          @(negedge clk);
          check("stall_msg_vld", 64'(msg_vld), 64'd0);
          check("stall_req_rdy", 64'(req_rdy), 64'd0);
        end
        @(posedge clk);
        #1 msg_rdy = 1'b1;
      end
    join
    wait_idle();
    check("t3_beats", 64'(n_beats - base), 64'd6);

    // Single-beat message from requester 1.
    done_delay = 6;
    base = n_beats;
    push_msg(1, 1, 8'h0F, 8'h41);
    send_msg(1, 1, 8'h0F, 8'h41);
    @(negedge clk);
    check("t4_busy_wait", 64'(busy), 64'd1);
    check("t4_rdy_wait", 64'(req_rdy), 64'd0);
    wait_idle();
    check("t4_beats", 64'(n_beats - base), 64'd1);

    // Stray completion while granted.
    done_delay = 4;
    check("t5_err_before", 64'(err), 64'd0);
    base = n_beats;
    push_msg(0, 4, 8'h01, 8'h51);
    fork
      send_msg(0, 4, 8'h01, 8'h51);
      begin
        wait_beats(base + 1);
        @(posedge clk);
        #1 stray_pulse = 1'b1;
        @(posedge clk);
        #1 stray_pulse = 1'b0;
        @(negedge clk);
        check("t5_err_set", 64'(err), 64'd1);
      end
    join
    wait_idle();
    check("t5_err_sticky", 64'(err), 64'd1);

    // Reset during beat 2 of a 4-beat message from requester 1.
    push_beat(1, 8'h61, 0, 8'hFF, 1'b0);
    push_beat(1, 8'h61, 1, 8'hFF, 1'b0);
    req_d[DW +: DW]  = beat_data(8'h61, 0);
    req_vb[BW +: BW] = 8'hFF;
    req_lst[1]       = 1'b0;
    req_vld[1]       = 1'b1;
    wait_hs(1);
    req_d[DW +: DW]  = beat_data(8'h61, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_rdy", 64'(req_rdy), 64'd0);
    check("t6_msg_vld", 64'(msg_vld), 64'd0);
    check("t6_msg_lst", 64'(msg_lst), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_gnt_id", 64'(gnt_id), 64'd0);
    check("t6_rslt", 64'(rslt_vld), 64'd0);
    check("t6_err", 64'(err), 64'd0);
    req_vld = '0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    repeat (5) @(negedge clk);
    push_msg(0, 1, 8'h07, 8'h71);
    push_msg(1, 1, 8'h1F, 8'h72);
    fork
      send_msg(0, 1, 8'h07, 8'h71);
      send_msg(1, 1, 8'h1F, 8'h72);
    join
    wait_idle();

    check("end_exp_beats_left", 64'(exp_q.size()), 64'd0);
    check("end_exp_rslt_left", 64'(exp_rslt.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sm3_msg_arb.md
Name: sm3_msg_arb

Overview:
- Round-robin arbiter that shares one SM3 padding core and its compression engine among NUM_REQ message requesters.
- Grants one requester per message. Muxes that requester's beats into the padder's input stream.
- Holds the grant until the compression engine signals hash completion, then routes the completion to the owner.
- Sits between the host-side message FIFOs and sm3_pad_core.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
DW, 64, message beat width in bits (32 or 64; must match SM3 input width config)
BW, DW/8, byte-valid width

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
req_d_i  input  NUM_REQ*DW  per-requester beat data, requester k at [k*DW +: DW]
req_vld_byte_i  input  NUM_REQ*BW  per-requester byte valids (meaningful on last beat)
req_vld_i  input  NUM_REQ  per-requester beat valid
req_lst_i  input  NUM_REQ  per-requester last beat of message
req_rdy_o  output  NUM_REQ  per-requester ready; a beat transfers when req_vld_i[k] && req_rdy_o[k]
msg_inpt_d_o  output  DW  data to padder
msg_inpt_vld_byte_o  output  BW  byte valids to padder
msg_inpt_vld_o  output  1  beat valid to padder
msg_inpt_lst_o  output  1  last beat to padder
msg_inpt_rdy_i  input  1  padder ready
hash_done_i  input  1  one-cycle pulse from compression engine: digest of current message complete
rslt_vld_o  output  NUM_REQ  one-hot one-cycle pulse to the owning requester
gnt_id_o  output  3  index of current/last granted requester
busy_o  output  1  arbiter not IDLE
err_o  output  1  sticky protocol error flag

Behaviour:
- Reset (async, rst=1) values: state IDLE, rr pointer 0, gnt_id_o 0, req_rdy_o 0, msg_inpt_vld_o 0, msg_inpt_lst_o 0, rslt_vld_o 0, busy_o 0, err_o 0, beat counter 0.
- Reset mid-stream aborts the session. No rslt pulse is issued. The padder is reset by the same rst.
- States: IDLE, GRANT, WAIT_RSLT, DONE.
- IDLE:
  - If any req_vld_i[k], select the first asserting requester searching from rr pointer upward with wrap (pointer, pointer+1, ..., NUM_REQ-1, 0, ...).
  - Latch the selection into gnt_id_o and go to GRANT next cycle.
  - No beat transfers in IDLE, so first-beat latency is 1 cycle.
- GRANT:
  - req_rdy_o[gnt] = msg_inpt_rdy_i; all other req_rdy_o are 0.
  - msg_inpt_vld_o = req_vld_i[gnt] && msg_inpt_rdy_i. The padder samples valid unconditionally, so valid is never presented while ready is low.
  - msg_inpt_d_o, msg_inpt_vld_byte_o and msg_inpt_lst_o are combinational muxes of the granted lanes. lst_o is also gated by the transfer.
  - Each transfer increments a 16-bit beat counter (saturating at 0xFFFF; counter is internal).
  - A transfer with lst → WAIT_RSLT next cycle. A single-beat message goes GRANT → WAIT_RSLT after its one transfer.
- WAIT_RSLT:
  - All req_rdy_o are 0; msg_inpt_vld_o is 0.
  - On hash_done_i go to DONE.
- DONE (one cycle):
  - rslt_vld_o[gnt] = 1 (registered, so one cycle after hash_done_i).
  - rr pointer = gnt+1 mod NUM_REQ.
  - Beat counter cleared; return to IDLE.
- busy_o = state != IDLE.
- Fairness: a requester that has just finished cannot win again while another requester is asserting valid in IDLE.
- hash_done_i in IDLE, GRANT or DONE is ignored for sequencing and sets err_o. A lone valid on a non-granted lane is not an error.
- err_o is cleared only by rst.
- Lost completion: hash_done_i never arriving leaves the arbiter in WAIT_RSLT indefinitely. Recovery is by rst.
- Non-granted requesters' data and valids have no effect on any output.

Test Plan:
- Req0 sends 3 beats (last beat vld_byte=0xF0), rdy held 1, hash_done 10 cycles later → gnt_id_o=0, 3 padder beats with lst on the 3rd, vld_byte 0xF0 passed through, rslt_vld_o=2'b01 for exactly one cycle one cycle after hash_done, busy_o falls.
- Req0 and Req1 both valid from reset → order req0, req1, req0; rslt_vld_o pulses 01 then 10 then 01.
- msg_inpt_rdy_i low for 4 cycles mid-message → msg_inpt_vld_o and req_rdy_o low during stall, no beat lost or duplicated, data order intact.
- Single-beat message (vld and lst on the same beat) from req1 → one padder beat with lst=1, state reaches WAIT_RSLT, rslt_vld_o=2'b10 after hash_done.
- hash_done_i pulsed while in GRANT → err_o=1 and stays 1, session continues normally to its own completion.
- rst asserted during beat 2 of a 4-beat message → all outputs at reset values immediately, no rslt_vld_o pulse, next grant starts from requester 0.
